// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO with a valid/ready push port.
// Frames go out LSB first and back to back while words are queued.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned UART_BPS   = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic [DATA_BITS-1:0]        s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic                        tx,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int unsigned BaudW = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
   localparam int unsigned BitW  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
   localparam int unsigned LvlW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PtrW  = (LvlW > 1) ? LvlW - 1 : 1;

   localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_CNT_MAX - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
   localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
   localparam logic [LvlW-1:0]  LvlFull  = LvlW'(FIFO_DEPTH);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : g_bad_parity
      $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
   end
   if (BAUD_CNT_MAX < 2) begin : g_bad_baud
      $fatal(1, "uart_tx_fifo: CLK_FREQ/UART_BPS must be >= 2");
   end

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                 state_q, state_d;
   logic [BaudW-1:0]       baud_q, baud_d;
   logic [BitW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]        count_q, count_d;
   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

   logic                   push, pop, load, baud_end;
   logic [DATA_BITS-1:0]   head;

   assign s_ready  = (count_q != LvlFull);
   assign push     = s_valid && s_ready;
   assign head     = mem_q[rd_ptr_q];
   assign baud_end = (baud_q == BaudLast);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      load    = 1'b0;
      if (state_q != StIdle) begin
         baud_d = baud_end ? '0 : baud_q + BaudW'(1);
      end
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            load = (count_q != '0);
         end
         StStart: begin
            if (baud_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (baud_end) begin
               if (bit_q == BitLast) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     tx_d    = par_q;
                     state_d = StParity;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StStop;
                  end
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BitW'(1);
               end
            end
         end
         StParity: begin
            if (baud_end) begin
               tx_d    = 1'b1;
               bit_d   = '0;
               state_d = StStop;
            end
         end
         StStop: begin
            if (baud_end) begin
               if (bit_q == StopLast) begin
                  done_d  = 1'b1;
                  bit_d   = '0;
                  state_d = StIdle;
                  // Next queued word starts on the same edge: no idle gap.
                  load    = (count_q != '0);
               end else begin
                  bit_d = bit_q + BitW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         shift_d = head;
         par_d   = (PARITY == 2) ? ^head : ~^head;
         tx_d    = 1'b0;
         baud_d  = '0;
         state_d = StStart;
      end
   end

   assign pop = load;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + LvlW'(1);
      end else if (pop && !push) begin
         count_d = count_q - LvlW'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the cleared count marks every entry empty.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   assign tx         = tx_q;
   assign tx_busy    = (state_q != StIdle);
   assign tx_done    = done_q;
   assign fifo_level = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frames on four configurations, and a
// queue-based frame model checked every cycle against the 8N1 depth-4 instance.
module tb_uart_tx_fifo;

   localparam int Bit  = 10;
   localparam int Flen = 100;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic [3:0] vld;
   wire  [3:0] txv, busyv, donev;
   wire  [3:0] rdyv;
   wire  [4:0] lvl0, lvl1, lvl2;
   wire  [2:0] lvl_m;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   bit cmp_en = 0;

   // 0: 8E1, 1: 8O1, 2: 7N2, 3: 8N1 with a 4-deep FIFO (model-checked)
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(2),
      .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
      .sys_clk(clk), .sys_rst(rst), .s_data(din), .s_valid(vld[0]), .s_ready(rdyv[0]),
      .tx(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0]), .fifo_level(lvl0));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(1),
      .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
      .sys_clk(clk), .sys_rst(rst), .s_data(din), .s_valid(vld[1]), .s_ready(rdyv[1]),
      .tx(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1]), .fifo_level(lvl1));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(0),
      .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
      .sys_clk(clk), .sys_rst(rst), .s_data(din[6:0]), .s_valid(vld[2]), .s_ready(rdyv[2]),
      .tx(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2]), .fifo_level(lvl2));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(0),
      .STOP_BITS(1), .FIFO_DEPTH(4)) u_main (
      .sys_clk(clk), .sys_rst(rst), .s_data(din), .s_valid(vld[3]), .s_ready(rdyv[3]),
      .tx(txv[3]), .tx_busy(busyv[3]), .tx_done(donev[3]), .fifo_level(lvl_m));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame model: queue of accepted words plus position inside the current frame.
   logic [7:0] mq[$];
   bit         m_act  = 0;
   int         m_pos  = 0;
   logic [7:0] m_word = '0;
   bit         m_done = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_act  = 0;
         m_pos  = 0;
         m_done = 0;
      end else begin
         bit push, fend, popn;
         push   = vld[3] && (mq.size() < 4);
         fend   = m_act && (m_pos == Flen - 1);
         popn   = (!m_act || fend) && (mq.size() != 0);
         m_done = fend;
         if (fend) m_act = 0;
         if (popn) begin
            m_word = mq.pop_front();
            m_act  = 1;
            m_pos  = 0;
         end else if (m_act) begin
            m_pos++;
         end
         if (push) mq.push_back(din);
      end
   end

   function automatic logic m_tx_exp();
      int idx;
      if (!m_act) return 1'b1;
      idx = m_pos / Bit;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_word[idx-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_tx", {31'b0, txv[3]}, {31'b0, m_tx_exp()});
         chk("model_busy", {31'b0, busyv[3]}, {31'b0, m_act});
         chk("model_done", {31'b0, donev[3]}, {31'b0, m_done});
         chk("model_level", {29'b0, lvl_m}, mq.size());
         chk("model_ready", {31'b0, rdyv[3]}, {31'b0, mq.size() < 4});
      end
   end

   always @(negedge clk) if (donev[3] === 1'b1) done_cnt++;

   // Push one word into instance k and check the frame bit by bit at mid-bit.
   task automatic run_frame(input int k, input logic [7:0] d, input logic [15:0] bits,
                            input int nbits, input int flen, input string nm);
      int waited;
      int n;
      @(negedge clk);
      din    = d;
      vld[k] = 1'b1;
      @(negedge clk);
      vld[k] = 1'b0;
      waited = 0;
      while (txv[k] !== 1'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk({nm, "_latency"}, waited, 1);
      n = 0;
      while (n < flen + 20) begin
         if (donev[k] === 1'b1) break;
         chk({nm, "_busy"}, {31'b0, busyv[k]}, 1);
         if (n % Bit == Bit / 2 && n / Bit < nbits) begin
            chk($sformatf("%s_bit%0d", nm, n / Bit), {31'b0, txv[k]}, {31'b0, bits[n / Bit]});
         end
         @(negedge clk);
         n++;
      end
      chk({nm, "_length"}, n, flen);
      chk({nm, "_idle_busy"}, {31'b0, busyv[k]}, 0);
      chk({nm, "_idle_tx"}, {31'b0, txv[k]}, 1);
   endtask

   task automatic wait_main_idle(input string nm);
      int g;
      g = 0;
      while ((busyv[3] !== 1'b0 || lvl_m != 3'd0) && g < 1500) begin
         @(negedge clk);
         g++;
      end
      chk({nm, "_idle_reached"}, {31'b0, g < 1500}, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int  w;
      int  d0;
      bit  rdy;
      bit  seen_full;
      rst = 1'b1;
      din = '0;
      vld = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", {28'b0, txv}, 32'hF);
      chk("rst_busy", {28'b0, busyv}, 0);
      chk("rst_done", {28'b0, donev}, 0);
      chk("rst_ready", {28'b0, rdyv}, 32'hF);
      chk("rst_level", {29'b0, lvl_m}, 0);
      chk("rst_level_aux", {17'b0, lvl0, lvl1, lvl2}, 0);
      rst    = 1'b0;
      cmp_en = 1;

      // Parity on 0x07: even -> 1, odd -> 0; 7N2 on 0x41; 8N1 on 0xA5
      run_frame(0, 8'h07, 16'h060E, 11, 110, "even07");
      run_frame(1, 8'h07, 16'h040E, 11, 110, "odd07");
      run_frame(2, 8'h41, 16'h0382, 10, 100, "7n2_41");
      d0 = done_cnt;
      run_frame(3, 8'hA5, 16'h034A, 10, 100, "8n1_a5");
      @(negedge clk);
      chk("a5_one_done", done_cnt - d0, 1);

      // Hold s_valid with 0x00..0x07 into the 4-deep FIFO.
      seen_full = 0;
      d0 = done_cnt;
      @(negedge clk);
      din    = 8'h00;
      vld[3] = 1'b1;
      w      = 0;
      for (int g = 0; g < 3000 && w < 8; g++) begin
         rdy = rdyv[3];
         if (!rdy && !seen_full) begin
            seen_full = 1;
            chk("burst_full_level", {29'b0, lvl_m}, 4);
         end
         @(negedge clk);
         if (rdy) begin
            w++;
            din = 8'(w);
         end
      end
      vld[3] = 1'b0;
      chk("burst_words_pushed", w, 8);
      chk("burst_saw_full", {31'b0, seen_full}, 1);
      wait_main_idle("burst");
      chk("burst_done_pulses", done_cnt - d0, 8);

      // Push on the same edge as the frame-end pop with one word queued.
      d0 = done_cnt;
      @(negedge clk);
      din    = 8'h11;
      vld[3] = 1'b1;
      @(negedge clk);
      din    = 8'h22;
      @(negedge clk);
      vld[3] = 1'b0;
      chk("pp_started", {31'b0, txv[3]}, 0);
      repeat (99) @(negedge clk);
      chk("pp_level_before", {29'b0, lvl_m}, 1);
      din    = 8'h33;
      vld[3] = 1'b1;
      @(negedge clk);
      vld[3] = 1'b0;
      chk("pp_level_after", {29'b0, lvl_m}, 1);
      chk("pp_done", {31'b0, donev[3]}, 1);
      chk("pp_next_start", {31'b0, txv[3]}, 0);
      wait_main_idle("pp");
      chk("pp_done_pulses", done_cnt - d0, 3);

      // Reset in the middle of data bit 3 with two words queued.
      @(negedge clk);
      din    = 8'h51;
      vld[3] = 1'b1;
      @(negedge clk);
      din    = 8'h52;
      @(negedge clk);
      din    = 8'h53;
      @(negedge clk);
      vld[3] = 1'b0;
      repeat (44) @(negedge clk);
      chk("abort_pre_level", {29'b0, lvl_m}, 2);
      chk("abort_pre_tx", {31'b0, txv[3]}, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("abort_tx", {31'b0, txv[3]}, 1);
      chk("abort_busy", {31'b0, busyv[3]}, 0);
      chk("abort_level", {29'b0, lvl_m}, 0);
      chk("abort_ready", {31'b0, rdyv[3]}, 1);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      run_frame(3, 8'h3C, 16'h0278, 10, 100, "after_rst_3c");

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not reach its summary in time");
      $fatal(1, "watchdog expired");
   end

endmodule
